// File: rtl/tlb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tlb_ctrl
// Purpose : Shares the TLB CAM between I-fetch and D-memory requesters, walks
//           on miss, fills a round-robin victim and replays; global flush.
// Options : TLB_PERF_CNT_EN adds saturating hit/miss performance counters.
// Revision: 1.0
//------------------------------------------------------------------------------
module tlb_ctrl #(
   parameter int VPN_W   = 34,
   parameter int PFN_W   = 26,
   parameter int ENTRIES = 64,
   parameter int IDX_W   = 6
`ifdef TLB_PERF_CNT_EN
   ,
   parameter int CNT_W   = 32
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   input  logic [VPN_W-1:0] i_req_vpn,
   output logic             i_req_ready,
   input  logic             d_req_valid,
   input  logic [VPN_W-1:0] d_req_vpn,
   output logic             d_req_ready,
   output logic             resp_valid,
   output logic             resp_id,
   output logic [PFN_W-1:0] resp_pfn,
   output logic             resp_fault,
   input  logic             resp_ready,
   output logic [VPN_W-1:0] cam_vpn,
   input  logic             cam_hit,
   input  logic [PFN_W-1:0] cam_pfn,
   output logic             cam_we,
   output logic [IDX_W-1:0] cam_widx,
   output logic [VPN_W-1:0] cam_wvpn,
   output logic [PFN_W-1:0] cam_wpfn,
   output logic             cam_inval_all,
   output logic             ptw_req_valid,
   output logic [VPN_W-1:0] ptw_req_vpn,
   input  logic             ptw_req_ready,
   input  logic             ptw_rsp_valid,
   input  logic [PFN_W-1:0] ptw_rsp_pfn,
   input  logic             ptw_rsp_fault,
   input  logic             flush_req,
   output logic             flush_done
`ifdef TLB_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_hit_cnt,
   output logic [CNT_W-1:0] perf_miss_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WALK_REQ  = 3'd2,
      S_WALK_WAIT = 3'd3,
      S_FILL      = 3'd4,
      S_RESP      = 3'd5
   } state_t;

   state_t             r_state;
   logic [VPN_W-1:0]   r_vpn;
   logic               r_id;
   logic               r_prio;
   logic [IDX_W-1:0]   r_victim;
   logic               r_flush_pend;
   logic               r_replay;
   logic [PFN_W-1:0]   r_wpfn;
   logic [PFN_W-1:0]   r_resp_pfn;
   logic               r_resp_fault;

   logic w_can_grant;
   logic w_grant_i;
   logic w_grant_d;
   logic w_flush_go;

   // A pending flush blocks new grants so invalidation always precedes them.
   assign w_can_grant = (r_state == S_IDLE) && !r_flush_pend;
   assign w_grant_i   = w_can_grant && i_req_valid && (!d_req_valid || !r_prio);
   assign w_grant_d   = w_can_grant && d_req_valid && !w_grant_i;
   assign w_flush_go  = (r_state == S_IDLE) && r_flush_pend;

   assign i_req_ready   = w_grant_i;
   assign d_req_ready   = w_grant_d;
   assign resp_valid    = (r_state == S_RESP);
   assign resp_id       = r_id;
   assign resp_pfn      = r_resp_pfn;
   assign resp_fault    = r_resp_fault;
   assign cam_vpn       = r_vpn;
   assign cam_we        = (r_state == S_FILL);
   assign cam_widx      = r_victim;
   assign cam_wvpn      = r_vpn;
   assign cam_wpfn      = r_wpfn;
   assign cam_inval_all = w_flush_go;
   assign flush_done    = w_flush_go;
   assign ptw_req_valid = (r_state == S_WALK_REQ);
   assign ptw_req_vpn   = r_vpn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_vpn        <= '0;
         r_id         <= 1'b0;
         r_prio       <= 1'b0;
         r_victim     <= '0;
         r_flush_pend <= 1'b0;
         r_replay     <= 1'b0;
         r_wpfn       <= '0;
         r_resp_pfn   <= '0;
         r_resp_fault <= 1'b0;
      end else begin
         // A new flush arriving as the old one is applied stays pending.
         if (w_flush_go) r_flush_pend <= 1'b0;
         if (flush_req)  r_flush_pend <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_grant_i || w_grant_d) begin
                  r_vpn    <= w_grant_i ? i_req_vpn : d_req_vpn;
                  r_id     <= w_grant_d;
                  r_prio   <= w_grant_i;
                  r_replay <= 1'b0;
                  r_state  <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (cam_hit) begin
                  r_resp_pfn   <= cam_pfn;
                  r_resp_fault <= 1'b0;
                  r_state      <= S_RESP;
               end else begin
                  r_state      <= S_WALK_REQ;
               end
            end
            S_WALK_REQ: begin
               if (ptw_req_ready) r_state <= S_WALK_WAIT;
            end
            S_WALK_WAIT: begin
               if (ptw_rsp_valid) begin
                  if (ptw_rsp_fault) begin
                     r_resp_pfn   <= '0;
                     r_resp_fault <= 1'b1;
                     r_state      <= S_RESP;
                  end else begin
                     r_wpfn  <= ptw_rsp_pfn;
                     r_state <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               r_victim <= (r_victim == IDX_W'(ENTRIES - 1)) ? '0 : r_victim + IDX_W'(1);
               r_replay <= 1'b1;
               r_state  <= S_LOOKUP;
            end
            S_RESP: begin
               if (resp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef TLB_PERF_CNT_EN
   logic w_hit_evt;
   logic w_miss_evt;

   // Replayed lookups after a fill are not first-pass hits.
   assign w_hit_evt  = (r_state == S_LOOKUP) && cam_hit && !r_replay;
   assign w_miss_evt = (r_state == S_LOOKUP) && !cam_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_hit_cnt  <= '0;
         perf_miss_cnt <= '0;
      end else begin
         if (w_hit_evt && (perf_hit_cnt != '1))
            perf_hit_cnt <= perf_hit_cnt + CNT_W'(1);
         if (w_miss_evt && (perf_miss_cnt != '1))
            perf_miss_cnt <= perf_miss_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_tlb_ctrl
// Purpose : Self-checking bench for tlb_ctrl with a CAM/PTW environment and a
//           transaction-level TLB model.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_tlb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid, d_req_valid, i_req_ready, d_req_ready;
   logic [33:0] i_req_vpn, d_req_vpn;
   logic        resp_valid, resp_id, resp_fault, resp_ready;
   logic [25:0] resp_pfn;
   logic [33:0] cam_vpn, cam_wvpn, ptw_req_vpn;
   logic        cam_hit, cam_we, cam_inval_all;
   logic [25:0] cam_pfn, cam_wpfn, ptw_rsp_pfn;
   logic [5:0]  cam_widx;
   logic        ptw_req_valid, ptw_req_ready, ptw_rsp_valid, ptw_rsp_fault;
   logic        flush_req, flush_done;

   always #5 clk = ~clk;

   tlb_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_vpn(i_req_vpn), .i_req_ready(i_req_ready),
      .d_req_valid(d_req_valid), .d_req_vpn(d_req_vpn), .d_req_ready(d_req_ready),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_pfn(resp_pfn),
      .resp_fault(resp_fault), .resp_ready(resp_ready),
      .cam_vpn(cam_vpn), .cam_hit(cam_hit), .cam_pfn(cam_pfn),
      .cam_we(cam_we), .cam_widx(cam_widx), .cam_wvpn(cam_wvpn), .cam_wpfn(cam_wpfn),
      .cam_inval_all(cam_inval_all),
      .ptw_req_valid(ptw_req_valid), .ptw_req_vpn(ptw_req_vpn), .ptw_req_ready(ptw_req_ready),
      .ptw_rsp_valid(ptw_rsp_valid), .ptw_rsp_pfn(ptw_rsp_pfn), .ptw_rsp_fault(ptw_rsp_fault),
      .flush_req(flush_req), .flush_done(flush_done)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   function automatic logic [25:0] walk_pfn(input logic [33:0] v);
      if (v == 34'h5) return 26'h123;
      return v[25:0] ^ 26'h2A55A5;
   endfunction

   function automatic bit walk_fault(input logic [33:0] v);
      return v[33:32] == 2'b11;
   endfunction

   // CAM environment: storage written by the DUT (or preloaded by the bench)
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = '0;
   logic [33:0] pre_vpn = '0;
   logic [25:0] pre_pfn = '0;
   logic        e_v   [64];
   logic [33:0] e_vpn [64];
   logic [25:0] e_pfn [64];

   initial for (int k = 0; k < 64; k++) begin e_v[k] = 1'b0; e_vpn[k] = '0; e_pfn[k] = '0; end

   always_comb begin
      cam_hit = 1'b0;
      cam_pfn = '0;
      for (int k = 0; k < 64; k++)
         if (e_v[k] && e_vpn[k] == cam_vpn) begin cam_hit = 1'b1; cam_pfn = e_pfn[k]; end
   end

   always @(posedge clk) begin
      if (cam_inval_all) for (int k = 0; k < 64; k++) e_v[k] <= 1'b0;
      if (cam_we) begin e_v[cam_widx] <= 1'b1; e_vpn[cam_widx] <= cam_wvpn; e_pfn[cam_widx] <= cam_wpfn; end
      if (pre_we) begin e_v[pre_idx] <= 1'b1; e_vpn[pre_idx] <= pre_vpn; e_pfn[pre_idx] <= pre_pfn; end
   end

   // PTW environment: one cycle of back-pressure, then a result two cycles later
   initial begin
      logic [33:0] wv;
      ptw_req_ready = 1'b0; ptw_rsp_valid = 1'b0; ptw_rsp_pfn = '0; ptw_rsp_fault = 1'b0;
      forever begin
         @(posedge clk); #2;
         ptw_rsp_valid = 1'b0;
         if (ptw_req_valid) begin
            @(posedge clk); #2;
            ptw_req_ready = 1'b1; wv = ptw_req_vpn;
            @(posedge clk); #2;
            ptw_req_ready = 1'b0;
            repeat (2) @(posedge clk);
            #2;
            ptw_rsp_valid = 1'b1; ptw_rsp_pfn = walk_pfn(wv); ptw_rsp_fault = walk_fault(wv);
         end
      end
   end

   // Transaction-level model
   typedef struct { logic id; logic [25:0] pfn; logic fault; bit hit; int gcyc; } exp_resp_t;
   exp_resp_t   exp_resp [$];
   logic [65:0] exp_wr   [$];
   logic [33:0] exp_walk [$];
   bit          grant_log[$];
   int          widx_log [$];
   bit          m_v   [64];
   logic [33:0] m_vpn [64];
   logic [25:0] m_pfn [64];
   int          m_victim = 0;
   bit          m_prio = 0, m_flush_pend = 0, m_busy = 0, resp_seen = 0;
   int          cyc = 0, grant_cnt = 0, walk_cnt = 0, wr_cnt = 0, resp_cnt = 0, flush_cnt = 0;
   int          last_grant_cyc = 0, last_resp_cyc = 0, flush_cyc = 0;
   logic        last_resp_id, last_resp_fault;
   logic [25:0] last_resp_pfn, last_wpfn;
   logic [33:0] last_walk_vpn, last_wvpn;
   int          last_widx;

   initial for (int k = 0; k < 64; k++) begin m_v[k] = 0; m_vpn[k] = '0; m_pfn[k] = '0; end

   task automatic predict(input bit side, input logic [33:0] vpn);
      exp_resp_t r;
      logic [25:0] p;
      bit hit;
      hit = 0; p = '0;
      for (int k = 0; k < 64; k++) if (m_v[k] && m_vpn[k] == vpn) begin hit = 1; p = m_pfn[k]; end
      r.id = side; r.gcyc = cyc; r.hit = hit; r.fault = 1'b0; r.pfn = p;
      if (!hit) begin
         exp_walk.push_back(vpn);
         if (walk_fault(vpn)) begin
            r.fault = 1'b1; r.pfn = '0;
         end else begin
            r.pfn = walk_pfn(vpn);
            exp_wr.push_back({6'(m_victim), vpn, r.pfn});
            m_v[m_victim] = 1; m_vpn[m_victim] = vpn; m_pfn[m_victim] = r.pfn;
            m_victim = (m_victim + 1) % 64;
         end
      end
      exp_resp.push_back(r);
   endtask

   initial begin
      bit exp_inv, exp_gi, exp_gd;
      exp_resp_t r;
      logic [65:0] w;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            chk("rst_ctrl", {i_req_ready, d_req_ready, resp_valid, resp_id, resp_fault, cam_we,
                             cam_inval_all, ptw_req_valid, flush_done}, '0);
            chk("rst_data", {cam_widx, resp_pfn, cam_wpfn}, '0);
            chk("rst_vpn", cam_vpn | cam_wvpn | ptw_req_vpn, '0);
            m_victim = 0; m_prio = 0; m_flush_pend = 0; m_busy = 0; resp_seen = 0;
            exp_resp.delete(); exp_wr.delete(); exp_walk.delete();
         end else begin
            exp_inv = !m_busy && m_flush_pend;
            chk("inval_all", cam_inval_all, exp_inv);
            chk("flush_done", flush_done, exp_inv);
            chk("we_inval_excl", cam_we & cam_inval_all, 0);
            exp_gi = !m_busy && !m_flush_pend && i_req_valid && (!d_req_valid || !m_prio);
            exp_gd = !m_busy && !m_flush_pend && d_req_valid && !exp_gi;
            chk("grant_i", i_req_ready, exp_gi);
            chk("grant_d", d_req_ready, exp_gd);
            if (exp_inv) begin
               for (int k = 0; k < 64; k++) m_v[k] = 0;
               m_flush_pend = 0; flush_cnt++; flush_cyc = cyc;
            end
            if (exp_gi || exp_gd) begin
               m_prio = !exp_gd; m_busy = 1;
               grant_log.push_back(exp_gd); grant_cnt++; last_grant_cyc = cyc;
               predict(exp_gd, exp_gd ? d_req_vpn : i_req_vpn);
            end
            if (cam_we) begin
               if (exp_wr.size() == 0) chk("unexpected_fill", 1, 0);
               else begin
                  w = exp_wr.pop_front();
                  chk("fill_idx", cam_widx, w[65:60]);
                  chk("fill_vpn", cam_wvpn, w[59:26]);
                  chk("fill_pfn", cam_wpfn, w[25:0]);
               end
               wr_cnt++; last_widx = int'(cam_widx); last_wvpn = cam_wvpn; last_wpfn = cam_wpfn;
               widx_log.push_back(int'(cam_widx));
            end
            if (ptw_req_valid) begin
               if (exp_walk.size() == 0) chk("unexpected_walk", 1, 0);
               else begin
                  chk("walk_vpn", ptw_req_vpn, exp_walk[0]);
                  if (ptw_req_ready) begin
                     void'(exp_walk.pop_front()); walk_cnt++; last_walk_vpn = ptw_req_vpn;
                  end
               end
            end
            if (resp_valid) begin
               if (exp_resp.size() == 0) chk("unexpected_resp", 1, 0);
               else begin
                  r = exp_resp[0];
                  chk("resp_id", resp_id, r.id);
                  chk("resp_pfn", resp_pfn, r.pfn);
                  chk("resp_fault", resp_fault, r.fault);
                  if (!resp_seen && r.hit) chk("hit_latency", cyc - r.gcyc, 2);
                  resp_seen = 1;
                  if (resp_ready) begin
                     void'(exp_resp.pop_front()); resp_seen = 0; m_busy = 0; resp_cnt++;
                     last_resp_id = resp_id; last_resp_pfn = resp_pfn;
                     last_resp_fault = resp_fault; last_resp_cyc = cyc;
                  end
               end
            end
            if (flush_req) m_flush_pend = 1;
         end
         if (pre_we) begin m_v[pre_idx] = 1; m_vpn[pre_idx] = pre_vpn; m_pfn[pre_idx] = pre_pfn; end
      end
   end

   task automatic preload(input logic [5:0] idx, input logic [33:0] vpn, input logic [25:0] pfn);
      @(posedge clk); #1;
      pre_we = 1'b1; pre_idx = idx; pre_vpn = vpn; pre_pfn = pfn;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic req(input bit side, input logic [33:0] vpn);
      int g0;
      g0 = grant_cnt;
      @(posedge clk); #1;
      if (side) begin d_req_valid = 1'b1; d_req_vpn = vpn; end
      else      begin i_req_valid = 1'b1; i_req_vpn = vpn; end
      for (int c = 0; c < 400 && grant_cnt == g0; c++) begin @(posedge clk); #1; end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      if (grant_cnt == g0) chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_quiet();
      int c;
      for (c = 0; c < 400 && (m_busy || m_flush_pend || exp_resp.size() != 0); c++) @(posedge clk);
      if (c >= 400) chk("quiet_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int g0, w0, wr0, f0, l0, c;
      logic [3:0] ord;
      i_req_valid = 0; d_req_valid = 0; i_req_vpn = '0; d_req_vpn = '0;
      resp_ready = 1; flush_req = 0;
      preload(6'd40, 34'h1_0000_0001, 26'h0ABCDEF);
      preload(6'd62, 34'h10, 26'h1010);
      preload(6'd61, 34'h20, 26'h2020);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Both sides requesting continuously: grants alternate from I
      g0 = grant_cnt;
      @(posedge clk); #1;
      i_req_valid = 1; i_req_vpn = 34'h10; d_req_valid = 1; d_req_vpn = 34'h20;
      for (c = 0; c < 400 && grant_cnt < g0 + 4; c++) begin @(posedge clk); #1; end
      i_req_valid = 0; d_req_valid = 0;
      chk("alt_grants", grant_cnt - g0, 4);
      ord = '0;
      for (int k = 0; k < 4; k++) if (grant_log.size() > g0 + k) ord[3-k] = grant_log[g0+k];
      chk("alt_order", ord, 4'b0101);
      wait_quiet();

      // Hit
      w0 = walk_cnt;
      req(0, 34'h1_0000_0001);
      wait_quiet();
      chk("hit_id", last_resp_id, 0);
      chk("hit_pfn", last_resp_pfn, 26'h0ABCDEF);
      chk("hit_lat_lit", last_resp_cyc - last_grant_cyc, 2);
      chk("hit_no_walk", walk_cnt - w0, 0);

      // Miss, walk, fill at victim 0, replay
      w0 = walk_cnt;
      req(0, 34'h5);
      wait_quiet();
      chk("miss_walks", walk_cnt - w0, 1);
      chk("miss_walk_vpn", last_walk_vpn, 34'h5);
      chk("miss_widx", last_widx, 0);
      chk("miss_wvpn", last_wvpn, 34'h5);
      chk("miss_wpfn", last_wpfn, 26'h123);
      chk("miss_pfn", last_resp_pfn, 26'h123);

      // Fault with response back-pressure
      wr0 = wr_cnt;
      resp_ready = 0;
      req(1, 34'h3_0000_0007);
      for (c = 0; c < 200 && !resp_valid; c++) begin @(posedge clk); #1; end
      chk("fault_resp_seen", resp_valid, 1);
      repeat (3) @(posedge clk);
      #1;
      resp_ready = 1;
      wait_quiet();
      chk("fault_flag", last_resp_fault, 1);
      chk("fault_pfn", last_resp_pfn, 0);
      chk("fault_id", last_resp_id, 1);
      chk("fault_no_fill", wr_cnt - wr0, 0);

      // Flush during a walk: walk completes, flush precedes the next grant
      w0 = walk_cnt; f0 = flush_cnt;
      req(0, 34'h77);
      for (c = 0; c < 200 && walk_cnt == w0; c++) begin @(posedge clk); #1; end
      flush_req = 1;
      @(posedge clk); #1;
      flush_req = 0;
      req(0, 34'h77);
      chk("flush_after_resp", flush_cyc > last_resp_cyc, 1);
      chk("flush_before_grant", flush_cyc < last_grant_cyc, 1);
      wait_quiet();
      chk("flush_count", flush_cnt - f0, 1);
      chk("flush_rewalk", walk_cnt - w0, 2);
      chk("flush_widx", last_widx, 2);

      // Flush coincident with a fill: fill lands, then is invalidated
      w0 = walk_cnt;
      req(1, 34'h99);
      for (c = 0; c < 200 && !cam_we; c++) begin @(posedge clk); #1; end
      flush_req = 1;
      @(posedge clk); #1;
      flush_req = 0;
      wait_quiet();
      chk("fillflush_pfn", last_resp_pfn, 26'h2A553C);
      req(1, 34'h99);
      wait_quiet();
      chk("fillflush_rewalk", walk_cnt - w0, 2);
      chk("fillflush_widx", last_widx, 4);

      // Reset clears the victim pointer; 65 misses wrap it 0..63,0
      @(posedge clk); #1;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      l0 = widx_log.size();
      for (int k = 0; k < 65; k++) begin
         req(k[0], 34'h2000 + 34'(k));
         wait_quiet();
      end
      chk("wrap_fills", widx_log.size() - l0, 65);
      for (int k = 0; k < 65; k++)
         if (widx_log.size() > l0 + k) chk("wrap_idx", widx_log[l0+k], k % 64);

      chk("queues_drained", exp_resp.size() + exp_wr.size() + exp_walk.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
